// File: rtl/mem_stage.sv
// MEM pipeline stage: serialises loads/stores into byte transfers on an 8-bit
// memory-controller port and stalls the pipeline until each access completes.
module mem_stage #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            wAddr_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wData_i,
    input  logic [5:0]            aluop_i,
    input  logic [31:0]           mem_addr_i,
    output logic [4:0]            wb_wAddr,
    output logic                  wb_wreg,
    output logic [31:0]           wb_wData,
    output logic                  stallreq_mem,
    output logic                  mc_req,
    output logic                  mc_we,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    output logic [7:0]            mc_wdata,
    input  logic                  mc_gnt,
    input  logic [7:0]            mc_rdata
);

    localparam logic [5:0] EXE_LB_OP  = 6'h23;
    localparam logic [5:0] EXE_LH_OP  = 6'h21;
    localparam logic [5:0] EXE_LW_OP  = 6'h22;
    localparam logic [5:0] EXE_LBU_OP = 6'h24;
    localparam logic [5:0] EXE_LHU_OP = 6'h25;
    localparam logic [5:0] EXE_SB_OP  = 6'h28;
    localparam logic [5:0] EXE_SH_OP  = 6'h29;
    localparam logic [5:0] EXE_SW_OP  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        WAIT_LAST = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic        rd_pend_q, rd_pend_d;
    logic [1:0]  rd_idx_q, rd_idx_d;

    logic        is_mem_s;
    logic        is_store_s;
    logic [1:0]  last_idx_s;
    logic [31:0] load_data_s;

    logic [4:0]            wb_waddr_s;
    logic                  wb_wreg_s;
    logic [31:0]           wb_wdata_s;
    logic                  stall_s;
    logic                  mc_req_s;
    logic                  mc_we_s;
    logic [ADDR_WIDTH-1:0] mc_addr_s;
    logic [7:0]            mc_wdata_s;

    // Upper address bits beyond the controller's reach are intentionally dropped.
    logic unused_addr_s;
    assign unused_addr_s = ^mem_addr_i[31:ADDR_WIDTH];

    // Op decode: memory-op flag, direction and index of the last byte.
    always_comb begin
        is_mem_s   = 1'b1;
        is_store_s = 1'b0;
        last_idx_s = 2'd0;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP: last_idx_s = 2'd0;
            EXE_LH_OP, EXE_LHU_OP: last_idx_s = 2'd1;
            EXE_LW_OP:             last_idx_s = 2'd3;
            EXE_SB_OP: begin
                is_store_s = 1'b1;
                last_idx_s = 2'd0;
            end
            EXE_SH_OP: begin
                is_store_s = 1'b1;
                last_idx_s = 2'd1;
            end
            EXE_SW_OP: begin
                is_store_s = 1'b1;
                last_idx_s = 2'd3;
            end
            default: is_mem_s = 1'b0;
        endcase
    end

    // Load result extension from the assembled little-endian buffer.
    always_comb begin
        case (aluop_i)
            EXE_LB_OP:  load_data_s = {{24{buf_q[7]}}, buf_q[7:0]};
            EXE_LH_OP:  load_data_s = {{16{buf_q[15]}}, buf_q[15:0]};
            EXE_LBU_OP: load_data_s = {24'd0, buf_q[7:0]};
            EXE_LHU_OP: load_data_s = {16'd0, buf_q[15:0]};
            EXE_LW_OP:  load_data_s = buf_q;
            default:    load_data_s = 32'd0;
        endcase
    end

    // Next-state, byte sequencing, read capture and stage outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        rd_pend_d  = 1'b0;
        rd_idx_d   = rd_idx_q;
        wb_waddr_s = 5'd0;
        wb_wreg_s  = 1'b0;
        wb_wdata_s = 32'd0;
        stall_s    = 1'b0;
        mc_req_s   = 1'b0;
        mc_we_s    = 1'b0;
        mc_addr_s  = '0;
        mc_wdata_s = 8'd0;

        // Read data trails its grant by one cycle, so capture can overlap ACCESS.
        if (rd_pend_q) begin
            buf_d[8*rd_idx_q +: 8] = mc_rdata;
        end else begin
            buf_d = buf_q;
        end

        case (state_q)
            IDLE: begin
                if (is_mem_s) begin
                    stall_s = 1'b1;
                    cnt_d   = 2'd0;
                    buf_d   = 32'd0;
                    state_d = ACCESS;
                end else begin
                    wb_waddr_s = wAddr_i;
                    wb_wreg_s  = wreg_i;
                    wb_wdata_s = wData_i;
                end
            end
            ACCESS: begin
                stall_s    = 1'b1;
                mc_req_s   = 1'b1;
                mc_we_s    = is_store_s;
                mc_addr_s  = mem_addr_i[ADDR_WIDTH-1:0] + ADDR_WIDTH'(cnt_q);
                mc_wdata_s = wData_i[8*cnt_q +: 8];
                if (mc_gnt) begin
                    cnt_d     = cnt_q + 2'd1;
                    rd_pend_d = ~is_store_s;
                    rd_idx_d  = cnt_q;
                    if (cnt_q == last_idx_s) begin
                        state_d = is_store_s ? DONE : WAIT_LAST;
                    end else begin
                        state_d = ACCESS;
                    end
                end else begin
                    state_d = ACCESS;
                end
            end
            WAIT_LAST: begin
                stall_s = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (!is_store_s) begin
                    wb_waddr_s = wAddr_i;
                    wb_wreg_s  = wreg_i;
                    wb_wdata_s = load_data_s;
                end else begin
                    wb_waddr_s = 5'd0;
                    wb_wreg_s  = 1'b0;
                    wb_wdata_s = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces every output low regardless of state.
    assign wb_wAddr     = rst ? 5'd0  : wb_waddr_s;
    assign wb_wreg      = rst ? 1'b0  : wb_wreg_s;
    assign wb_wData     = rst ? 32'd0 : wb_wdata_s;
    assign stallreq_mem = rst ? 1'b0  : stall_s;
    assign mc_req       = rst ? 1'b0  : mc_req_s;
    assign mc_we        = rst ? 1'b0  : mc_we_s;
    assign mc_addr      = rst ? '0    : mc_addr_s;
    assign mc_wdata     = rst ? 8'd0  : mc_wdata_s;

    // State, byte counter, load buffer and pending-read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            buf_q     <= 32'd0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-wide memory model behind the controller port.
module tb_mem_stage;

    localparam logic [5:0] ADD = 6'h20;
    localparam logic [5:0] LB  = 6'h23;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h22;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wAddr_i;
    logic        wreg_i;
    logic [31:0] wData_i;
    logic [5:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [4:0]  wb_wAddr;
    logic        wb_wreg;
    logic [31:0] wb_wData;
    logic        stallreq_mem;
    logic        mc_req;
    logic        mc_we;
    logic [16:0] mc_addr;
    logic [7:0]  mc_wdata;
    logic        mc_gnt;
    logic [7:0]  mc_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:131071];
    logic [7:0] rd_q = 8'd0;

    mem_stage #(.ADDR_WIDTH(17)) dut (
        .clk(clk), .rst(rst),
        .wAddr_i(wAddr_i), .wreg_i(wreg_i), .wData_i(wData_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
        .wb_wAddr(wb_wAddr), .wb_wreg(wb_wreg), .wb_wData(wb_wData),
        .stallreq_mem(stallreq_mem),
        .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_gnt(mc_gnt), .mc_rdata(mc_rdata)
    );

    always #5 clk = ~clk;

    // Memory controller model: accepted writes land, accepted reads return next cycle.
    always @(posedge clk) begin
        if (mc_req && mc_gnt) begin
            if (mc_we) mem[mc_addr] = mc_wdata;
            else       rd_q <= mem[mc_addr];
        end
    end
    assign mc_rdata = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    // One memory op with grant held high; checks every cycle of the sequence.
    task automatic mem_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input int n, input bit st, input logic [31:0] exp_wb);
        @(negedge clk);
        aluop_i = op; mem_addr_i = addr; wData_i = data; wreg_i = 1'b1; wAddr_i = 5'd7; mc_gnt = 1'b1;
        #1;
        chk("idle_stall", {31'd0, stallreq_mem}, 32'd1);
        chk("idle_req", {31'd0, mc_req}, 32'd0);
        chk("idle_wreg", {31'd0, wb_wreg}, 32'd0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); #1;
            chk("acc_req", {31'd0, mc_req}, 32'd1);
            chk("acc_we", {31'd0, mc_we}, {31'd0, st});
            chk("acc_addr", {15'd0, mc_addr}, (addr + k) & 32'h1FFFF);
            chk("acc_stall", {31'd0, stallreq_mem}, 32'd1);
            if (st) chk("acc_wdata", {24'd0, mc_wdata}, (data >> (8 * k)) & 32'hFF);
        end
        if (!st) begin
            @(negedge clk); #1;
            chk("wait_req", {31'd0, mc_req}, 32'd0);
            chk("wait_stall", {31'd0, stallreq_mem}, 32'd1);
        end
        @(negedge clk); #1;
        chk("done_stall", {31'd0, stallreq_mem}, 32'd0);
        chk("done_req", {31'd0, mc_req}, 32'd0);
        chk("done_wreg", {31'd0, wb_wreg}, st ? 32'd0 : 32'd1);
        chk("done_waddr", {27'd0, wb_wAddr}, st ? 32'd0 : 32'd7);
        chk("done_wdata", wb_wData, st ? 32'd0 : exp_wb);
    endtask

    initial begin
        rst = 1'b1; wAddr_i = 5'd3; wreg_i = 1'b1; wData_i = 32'h55; aluop_i = ADD;
        mem_addr_i = 32'd0; mc_gnt = 1'b1;
        @(negedge clk); #1;
        chk("rst_wreg", {31'd0, wb_wreg}, 32'd0);
        chk("rst_wdata", wb_wData, 32'd0);
        chk("rst_stall", {31'd0, stallreq_mem}, 32'd0);
        chk("rst_req", {31'd0, mc_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD pass-through
        aluop_i = ADD; wData_i = 32'h1234; wreg_i = 1'b1; wAddr_i = 5'd5; #1;
        chk("add_wdata", wb_wData, 32'h1234);
        chk("add_wreg", {31'd0, wb_wreg}, 32'd1);
        chk("add_waddr", {27'd0, wb_wAddr}, 32'd5);
        chk("add_stall", {31'd0, stallreq_mem}, 32'd0);
        chk("add_req", {31'd0, mc_req}, 32'd0);

        // Word store then word load at 0x100
        mem_op(SW, 32'h100, 32'h12345678, 4, 1'b1, 32'd0);
        mem_op(LW, 32'h100, 32'd0, 4, 1'b0, 32'h12345678);

        // Byte 0x80: back-to-back SB then LB, then LBU
        mem_op(SB, 32'h200, 32'h00000080, 1, 1'b1, 32'd0);
        mem_op(LB, 32'h200, 32'd0, 1, 1'b0, 32'hFFFFFF80);
        mem_op(LBU, 32'h200, 32'd0, 1, 1'b0, 32'h00000080);

        // Halfword bytes 01 F0
        mem_op(SH, 32'h300, 32'h0000F001, 2, 1'b1, 32'd0);
        mem_op(LH, 32'h300, 32'd0, 2, 1'b0, 32'hFFFFF001);
        mem_op(LHU, 32'h300, 32'd0, 2, 1'b0, 32'h0000F001);

        // SH across the address wrap with grant 1,0,1
        @(negedge clk);
        aluop_i = SH; mem_addr_i = 32'h1FFFF; wData_i = 32'hAABB; wreg_i = 1'b1; wAddr_i = 5'd9; mc_gnt = 1'b1;
        #1; chk("shw_idle_stall", {31'd0, stallreq_mem}, 32'd1);
        @(negedge clk); mc_gnt = 1'b1; #1;
        chk("shw_addr0", {15'd0, mc_addr}, 32'h1FFFF);
        chk("shw_data0", {24'd0, mc_wdata}, 32'hBB);
        @(negedge clk); mc_gnt = 1'b0; #1;
        chk("shw_req_hold", {31'd0, mc_req}, 32'd1);
        chk("shw_addr1_hold", {15'd0, mc_addr}, 32'h0);
        chk("shw_data1_hold", {24'd0, mc_wdata}, 32'hAA);
        @(negedge clk); mc_gnt = 1'b1; #1;
        chk("shw_addr1", {15'd0, mc_addr}, 32'h0);
        chk("shw_stall1", {31'd0, stallreq_mem}, 32'd1);
        @(negedge clk); #1;
        chk("shw_done_stall", {31'd0, stallreq_mem}, 32'd0);
        chk("shw_done_wreg", {31'd0, wb_wreg}, 32'd0);
        mem_op(LHU, 32'h1FFFF, 32'd0, 2, 1'b0, 32'h0000AABB);

        // Reset during SW after two granted bytes
        @(negedge clk);
        aluop_i = SW; mem_addr_i = 32'h400; wData_i = 32'hDEADBEEF; mc_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("rsw_addr1", {15'd0, mc_addr}, 32'h401);
        @(negedge clk); rst = 1'b1; #1;
        chk("rsw_req", {31'd0, mc_req}, 32'd0);
        chk("rsw_stall", {31'd0, stallreq_mem}, 32'd0);
        chk("rsw_addr", {15'd0, mc_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0; aluop_i = 6'd0; wData_i = 32'd0; wreg_i = 1'b0; wAddr_i = 5'd0; mem_addr_i = 32'd0;
        #1;
        chk("post_rst_req", {31'd0, mc_req}, 32'd0);
        chk("post_rst_stall", {31'd0, stallreq_mem}, 32'd0);
        chk("post_rst_wdata", wb_wData, 32'd0);
        mem_op(LW, 32'h100, 32'd0, 4, 1'b0, 32'h12345678);
        mem_op(LH, 32'h400, 32'd0, 2, 1'b0, 32'hFFFFBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
